cic_up_interp: RTL and testbench

- Downstream neighbour of the half-band interpolator in the TX/DAC path.
- Consumes the half-band's low-rate output sample and strobe (its ce_out).
- Performs N-stage CIC interpolation by R = 2^R_LOG2 up to the high-rate tick domain.
- Normalises the CIC gain and rounds/saturates back to DW for the DAC/NCO mixer.

---
 rtl/cic_up_interp_pkg.sv | 47 ++++
 rtl/cic_up_interp_int_stage.sv | 23 ++
 rtl/cic_up_interp.sv | 134 +++++++++++++
 tb/tb_cic_up_interp.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/cic_up_interp_pkg.sv
// Shared DSP helpers for the TX interpolation chain: default widths,
// CIC width/shift derivation, saturation limits and round/saturate.
package cic_up_interp_pkg;

    localparam int CIC_DW     = 16;
    localparam int CIC_N      = 3;
    localparam int CIC_R_LOG2 = 3;
    localparam int WIDE_W     = 64;

    typedef logic signed [WIDE_W-1:0] wide_t;

    // Internal width needed so the comb/integrator chain wraps correctly.
    function automatic int cic_iw(input int dw, input int n, input int r_log2);
        return dw + n * r_log2;
    endfunction

    // Right shift that removes the R^(N-1) DC gain of the zero-stuffed CIC.
    function automatic int cic_shift(input int n, input int r_log2);
        return (n - 1) * r_log2;
    endfunction

    function automatic wide_t sat_max(input int dw);
        return (64'sd1 <<< (dw - 1)) - 64'sd1;
    endfunction

    function automatic wide_t sat_min(input int dw);
        return -(64'sd1 <<< (dw - 1));
    endfunction

    // Round half up, arithmetic shift, then clamp to a dw-bit signed range.
    // Works in a wide domain so the rounding offset can never wrap.
    function automatic wide_t round_sat(input wide_t x, input int shift, input int dw);
        wide_t t;
        t = x;
        if (shift > 0) begin
            t = x + (64'sd1 <<< (shift - 1));
            t = t >>> shift;
        end
        if (t > sat_max(dw)) begin
            t = sat_max(dw);
        end else if (t < sat_min(dw)) begin
            t = sat_min(dw);
        end
        return t;
    endfunction

endpackage

// File: rtl/cic_up_interp_int_stage.sv
// One CIC integrator: an IW-bit wrap-around accumulator advanced on en.
import cic_up_interp_pkg::*;

module cic_int_stage #(
    parameter int IW = cic_iw(CIC_DW, CIC_N, CIC_R_LOG2)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic signed [IW-1:0] din,
    output logic signed [IW-1:0] acc
);

    // Accumulate on each high-rate tick; overflow wraps by design.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + din;
        end
    end

endmodule

// File: rtl/cic_up_interp.sv
// CIC interpolator: comb pipeline at the low rate, zero-stuffing hand-off,
// integrators on the high-rate tick, gain normalisation with round/saturate.
import cic_up_interp_pkg::*;

module cic_up_interp #(
    parameter int DW     = CIC_DW,
    parameter int N      = CIC_N,
    parameter int R_LOG2 = CIC_R_LOG2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ce_in,
    input  logic signed [DW-1:0] filter_in,
    input  logic                 ce_hi,
    input  logic                 clear_err,
    output logic signed [DW-1:0] filter_out,
    output logic                 ce_out,
    output logic                 overrun
);

    localparam int IW    = cic_iw(DW, N, R_LOG2);
    localparam int SHIFT = cic_shift(N, R_LOG2);

    logic signed [IW-1:0] comb_out;
    logic                 comb_valid;
    logic signed [IW-1:0] comb_hold;
    logic                 pending;
    logic signed [IW-1:0] inject;
    logic signed [IW-1:0] last_acc;
    wide_t                last_wide;

    // Comb chain: each stage is a registered difference that only moves
    // (and only updates its delay) when its input is valid, so back-to-back
    // samples stream through one per clk.
    for (genvar k = 0; k < N; k++) begin : g_comb
        logic signed [IW-1:0] x_in;
        logic                 v_in;
        logic signed [IW-1:0] data_q;
        logic signed [IW-1:0] prev_q;
        logic                 vld_q;

        if (k == 0) begin : g_first
            assign x_in = {{(IW-DW){filter_in[DW-1]}}, filter_in};
            assign v_in = ce_in;
        end else begin : g_next
            assign x_in = g_comb[k-1].data_q;
            assign v_in = g_comb[k-1].vld_q;
        end

        // Difference against the last valid input of this stage.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                data_q <= '0;
                prev_q <= '0;
                vld_q  <= 1'b0;
            end else begin
                vld_q <= v_in;
                if (v_in) begin
                    data_q <= x_in - prev_q;
                    prev_q <= x_in;
                end
            end
        end
    end

    assign comb_out   = g_comb[N-1].data_q;
    assign comb_valid = g_comb[N-1].vld_q;

    // Zero-stuffing: a held comb result is injected once, otherwise zero.
    assign inject = pending ? comb_hold : '0;

    // Hand-off between the comb and tick domains. A new comb result always
    // loads; if it coincides with a tick the previous hold is the one being
    // consumed on that same edge, so only a result landing on an unconsumed
    // hold without a tick counts as an overrun. Setting beats clearing.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            comb_hold <= '0;
            pending   <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (comb_valid) begin
                comb_hold <= comb_out;
                pending   <= 1'b1;
            end else if (ce_hi) begin
                pending <= 1'b0;
            end

            if (comb_valid && pending && !ce_hi) begin
                overrun <= 1'b1;
            end else if (clear_err) begin
                overrun <= 1'b0;
            end
        end
    end

    // Integrator chain; each stage adds the previous stage's registered
    // value, giving one tick of latency per stage.
    for (genvar k = 0; k < N; k++) begin : g_int
        logic signed [IW-1:0] din;
        logic signed [IW-1:0] acc;

        if (k == 0) begin : g_first
            assign din = inject;
        end else begin : g_next
            assign din = g_int[k-1].acc;
        end

        cic_int_stage #(.IW(IW)) u_stage (
            .clk   (clk),
            .reset (reset),
            .en    (ce_hi),
            .din   (din),
            .acc   (acc)
        );
    end

    assign last_acc  = g_int[N-1].acc;
    assign last_wide = {{(WIDE_W-IW){last_acc[IW-1]}}, last_acc};

    // Normalise, round and saturate on each tick; strobe follows one clk later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filter_out <= '0;
            ce_out     <= 1'b0;
        end else begin
            ce_out <= ce_hi;
            if (ce_hi) begin
                filter_out <= DW'(round_sat(last_wide, SHIFT, DW));
            end
        end
    end

endmodule

// File: tb/tb_cic_up_interp.sv
// Scoreboard bench for cic_up_interp: directed streams push hand-computed
// expectations, a negedge monitor pops one entry per ce_out.
module tb_cic_up_interp;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               ce_in = 1'b0;
    logic               ce_hi = 1'b0;
    logic               clear_err = 1'b0;
    logic signed [15:0] filter_in = '0;
    logic signed [15:0] filter_out;
    logic               ce_out;
    logic               overrun;

    always #5 clk = ~clk;

    cic_up_interp dut (
        .clk        (clk),
        .reset      (reset),
        .ce_in      (ce_in),
        .filter_in  (filter_in),
        .ce_hi      (ce_hi),
        .clear_err  (clear_err),
        .filter_out (filter_out),
        .ce_out     (ce_out),
        .overrun    (overrun)
    );

    // kind: 0 = don't care (settling), 1 = exact value, 2 = non-decreasing
    typedef struct {
        int    kind;
        int    val;
        string tag;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;
    int   prev_out = 0;
    int   imp_sum = 0;
    bit   imp_on = 1'b0;
    int   h_tab[22] = '{1, 3, 6, 10, 15, 21, 28, 36, 42, 46, 48,
                        48, 46, 42, 36, 28, 21, 15, 10, 6, 3, 1};

    task automatic check(input string tag, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", tag, act, req);
        end
    endtask

    task automatic push(input int kind, input int val, input string tag);
        exp_t e;
        e.kind = kind;
        e.val  = val;
        e.tag  = tag;
        sb.push_back(e);
    endtask

    task automatic drive(input int ci, input int x, input int ch, input int clr);
        @(negedge clk);
        ce_in     = (ci != 0);
        filter_in = 16'(x);
        ce_hi     = (ch != 0);
        clear_err = (clr != 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        ce_in = 1'b0;
        ce_hi = 1'b0;
        clear_err = 1'b0;
        filter_in = '0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic int sample_val(input int mode, input int m);
        case (mode)
            0: return 1000;
            1: return (m == 0) ? 64 : 0;
            2: return (m < 8) ? -32768 : 32767;
            default: return 0;
        endcase
    endfunction

    // ce_in every 32 clk at phase 0, ce_hi every 4 clk at phase 1.
    task automatic run_stream(input int mode, input int n);
        for (int c = 0; c < 32 * n; c++) begin
            drive((c % 32) == 0 ? 1 : 0, sample_val(mode, c / 32), (c % 4) == 1 ? 1 : 0, 0);
        end
        drive(0, 0, 0, 0);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_drain"}, sb.size(), 0);
        sb.delete();
    endtask

    // Monitor: one scoreboard entry per output strobe.
    always @(negedge clk) begin
        if (!reset && ce_out) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ce_out actual=%0d required=none", filter_out);
            end else begin
                mon_e = sb.pop_front();
                if (mon_e.kind == 1) begin
                    check(mon_e.tag, int'(filter_out), mon_e.val);
                end else if (mon_e.kind == 2) begin
                    checks++;
                    if (int'(filter_out) < prev_out) begin
                        failures++;
                        $display("FAIL %s actual=%0d required>=%0d", mon_e.tag, filter_out, prev_out);
                    end
                end
            end
            prev_out = int'(filter_out);
            if (imp_on) imp_sum += int'(filter_out);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        check("reset_filter_out", int'(filter_out), 0);
        check("reset_ce_out", int'(ce_out), 0);
        check("reset_overrun", int'(overrun), 0);
        reset = 1'b0;

        // DC: settles at the input level once the response has filled in.
        do_reset();
        for (int j = 0; j < 64; j++) push(j < 26 ? 0 : 1, 1000, "dc");
        run_stream(0, 8);
        drain("dc");
        check("dc_overrun", int'(overrun), 0);

        // Impulse of 64: triangular-cubic response scaled to unit steps.
        do_reset();
        for (int j = 0; j < 40; j++) push(1, (j >= 4 && j < 26) ? h_tab[j-4] : 0, "impulse");
        imp_sum = 0;
        imp_on  = 1'b1;
        run_stream(1, 5);
        drain("impulse");
        imp_on = 1'b0;
        check("impulse_sum", imp_sum, 512);

        // Full scale: exact negative limit, monotonic step, exact positive limit.
        do_reset();
        for (int j = 0; j < 128; j++) begin
            if (j < 25)      push(0, 0, "fs_settle");
            else if (j < 68) push(1, -32768, "fs_neg");
            else if (j < 89) push(2, 0, "fs_mono");
            else             push(1, 32767, "fs_pos");
        end
        run_stream(2, 16);
        drain("fs");
        check("fs_overrun", int'(overrun), 0);

        // Coincidence: comb result lands on a tick with nothing pending.
        do_reset();
        push(1, 0, "coinc0"); push(1, 0, "coinc1"); push(1, 0, "coinc2");
        push(1, 0, "coinc3"); push(1, 2, "coinc4"); push(1, 5, "coinc5");
        push(1, 9, "coinc6");
        for (int c = 0; c < 28; c++) drive(c == 0 ? 1 : 0, c == 0 ? 100 : 0, (c % 4) == 3 ? 1 : 0, 0);
        drive(0, 0, 0, 0);
        drain("coinc");
        check("coinc_overrun", int'(overrun), 0);

        // Overrun: two samples 2 clk apart, no tick between comb results.
        do_reset();
        drive(1, 100, 0, 0);
        drive(0, 0, 0, 0);
        drive(1, 200, 0, 0);
        for (int c = 0; c < 4; c++) drive(0, 0, 0, 0);
        check("overrun_set", int'(overrun), 1);
        push(1, 0, "ovr_inj0"); push(1, 0, "ovr_inj1"); push(1, 0, "ovr_inj2");
        push(1, -2, "ovr_inj3"); push(1, -5, "ovr_inj4"); push(1, -9, "ovr_inj5");
        for (int c = 0; c < 24; c++) drive(0, 0, (c % 4) == 0 ? 1 : 0, 0);
        drive(0, 0, 0, 0);
        drain("ovr_inj");
        drive(0, 0, 0, 1);
        drive(0, 0, 0, 0);
        check("overrun_clear", int'(overrun), 0);
        drive(1, 300, 0, 0);
        drive(1, 300, 0, 0);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 1);
        drive(0, 0, 0, 0);
        check("overrun_set_wins", int'(overrun), 1);

        // Reset mid-stream while an output strobe is high.
        drive(0, 0, 1, 0);
        @(posedge clk);
        #1;
        check("pre_reset_ce_out", int'(ce_out), 1);
        reset = 1'b1;
        #1;
        check("async_reset_filter_out", int'(filter_out), 0);
        check("async_reset_ce_out", int'(ce_out), 0);
        check("async_reset_overrun", int'(overrun), 0);
        @(negedge clk);
        ce_hi = 1'b0;
        reset = 1'b0;

        for (int j = 0; j < 16; j++) push(1, 0, "post_reset_zero");
        run_stream(3, 2);
        drain("post_reset");
        check("post_reset_overrun", int'(overrun), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
